count_pwm_gen: RTL and testbench

- Consumes the free-running 4-bit count from the upstream binary counter stage and turns it into a PWM waveform.
- One PWM period equals one full count cycle, 2^WIDTH clocks.
- New duty values arrive over a valid/ready handshake into a shadow register. The active duty is updated only at a period boundary, so no partial periods or glitches occur.
- Sits between the counter and LED/motor-drive output logic.

---
 rtl/count_pwm_gen.sv | 165 ++++++++++++++++
 tb/tb_count_pwm_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_pwm_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : count_pwm_gen
// Purpose  : Turns the free-running count of an upstream binary counter into
//            a PWM waveform. One PWM period is one full count cycle
//            (2^WIDTH clocks). New duty values are taken over a valid/ready
//            handshake into a shadow register. They are applied only at a
//            period boundary (a MAX->0 count transition), so no period is
//            ever cut short or glitched.
// Ports    : clk          - system clock
//            reset        - asynchronous, active-high reset
//            count        - upstream counter value (expected +1 per clk)
//            duty_in      - requested high clocks per period
//            duty_valid   - duty_in valid
//            duty_ready   - shadow register empty, can accept a value
//            pwm_out      - registered PWM output (1 clk after count)
//            period_start - one-clk pulse aligned with pwm_out of count 0
//            duty_active  - duty currently applied
//            seq_err      - sticky count-sequence error (optional feature)
// Options  : COUNT_PWM_SEQ_CHECK_EN - when defined, checks in RUN that count
//            steps by +1. A bad step sets seq_err, forces pwm_out low and
//            returns to IDLE to resync on the next MAX->0 transition.
// Revision : 1.0 - initial release
// ============================================================================
module count_pwm_gen #(
  parameter int WIDTH      = 4,
  parameter int RESET_DUTY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] duty_active,
  output logic             seq_err
);

  localparam logic [WIDTH-1:0] MAX_COUNT    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RESET_DUTY_V = RESET_DUTY[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q,        state_d;
  logic [WIDTH-1:0] prev_count_q,   prev_count_d;
  logic             pwm_out_q,      pwm_out_d;
  logic             period_start_q, period_start_d;
  logic [WIDTH-1:0] duty_active_q,  duty_active_d;
  logic [WIDTH-1:0] shadow_q,       shadow_d;
  logic             shadow_full_q,  shadow_full_d;

  logic             boundary;
  logic             accept;
  logic             seq_bad;
  logic [WIDTH-1:0] eff_duty;

  // MAX->0 rather than count==0 alone, so a counter parked at 0 (e.g. held
  // in its own reset) never produces period boundaries.
  assign boundary = (prev_count_q == MAX_COUNT) && (count == '0);
  assign accept   = duty_valid && !shadow_full_q;
  // A pending shadow value takes effect for count 0 of the new period.
  assign eff_duty = (boundary && shadow_full_q) ? shadow_q : duty_active_q;

`ifdef COUNT_PWM_SEQ_CHECK_EN
  logic             seq_err_q, seq_err_d;
  logic [WIDTH-1:0] count_expect;

  assign count_expect = prev_count_q + ONE;
  assign seq_bad      = (state_q == RUN) && (count != count_expect);

  always_comb begin
    seq_err_d = seq_err_q | seq_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  logic unused_one;
  assign unused_one = ^ONE;
  assign seq_bad    = 1'b0;
  assign seq_err    = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    prev_count_d   = count;
    pwm_out_d      = 1'b0;
    period_start_d = boundary;
    duty_active_d  = duty_active_q;
    shadow_d       = shadow_q;
    shadow_full_d  = shadow_full_q;

    // Shadow transfer happens on any boundary, in IDLE as well as RUN.
    // accept requires an empty shadow, so it never collides with a transfer;
    // a value accepted on a boundary waits for the next one.
    if (boundary && shadow_full_q) begin
      duty_active_d = shadow_q;
      shadow_full_d = 1'b0;
    end
    if (accept) begin
      shadow_d      = duty_in;
      shadow_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // The boundary cycle itself is count 0 of the first period.
        if (boundary) begin
          state_d   = RUN;
          pwm_out_d = (count < eff_duty);
        end
      end
      RUN: begin
        if (seq_bad) begin
          state_d   = IDLE;
          pwm_out_d = 1'b0;
        end else begin
          pwm_out_d = (count < eff_duty);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      prev_count_q   <= '0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      duty_active_q  <= RESET_DUTY_V;
      shadow_q       <= '0;
      shadow_full_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_count_q   <= prev_count_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      duty_active_q  <= duty_active_d;
      shadow_q       <= shadow_d;
      shadow_full_q  <= shadow_full_d;
    end
  end

  assign duty_ready   = !shadow_full_q;
  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign duty_active  = duty_active_q;

endmodule
`default_nettype wire

// File: tb/tb_count_pwm_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_count_pwm_gen
// Purpose  : Self-checking bench for count_pwm_gen. Drives the count like the
//            upstream counter, writes duty values over the handshake, and
//            compares every output each clock against a period-level
//            reference model. The number of high clocks in each complete
//            period is also checked against the duty in force.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_pwm_gen;

  localparam int W    = 4;
  localparam int MAXC = 15;
  localparam int RD   = 0;
`ifdef COUNT_PWM_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] count;
  logic [W-1:0] duty_in;
  logic         duty_valid;
  wire          duty_ready;
  wire          pwm_out;
  wire          period_start;
  wire  [W-1:0] duty_active;
  wire          seq_err;

  count_pwm_gen #(.WIDTH(W), .RESET_DUTY(RD)) dut (
    .clk          (clk),
    .reset        (reset),
    .count        (count),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active),
    .seq_err      (seq_err)
  );

  always #5 clk = ~clk;

  // Reference model: running flag, last count seen, applied duty, pending
  // duty, and the outputs expected after the most recent edge.
  bit m_run, m_full, m_pwm, m_ps, m_err;
  int m_prev, m_active, m_shadow;
  // Per-period high-clock accounting.
  bit per_valid;
  int per_len, hi_cnt, per_duty;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_prev = 0; m_active = RD; m_shadow = 0; m_full = 0;
    m_pwm = 0; m_ps = 0; m_err = 0; per_valid = 0; per_len = 0; hi_cnt = 0;
  endtask

  // One clock edge as seen by the model. Returns whether duty_in was taken.
  task automatic model_edge(input int c, input bit v, input int d, output bit acc);
    bit bnd, bad;
    bnd = (m_prev == MAXC) && (c == 0);
    bad = SEQ && m_run && (c != ((m_prev + 1) % (MAXC + 1)));
    acc = v && !m_full;
    if (bnd && m_full) begin
      m_active = m_shadow;
      m_full   = 0;
    end
    if (acc) begin
      m_shadow = d;
      m_full   = 1;
    end
    if (bad) begin
      m_err = 1; m_run = 0; m_pwm = 0; per_valid = 0;
    end else begin
      if (bnd) m_run = 1;
      m_pwm = m_run && (c < m_active);
    end
    m_ps   = bnd;
    m_prev = c;
  endtask

  task automatic compare_all();
    check("pwm_out",      pwm_out,      m_pwm);
    check("period_start", period_start, m_ps);
    check("duty_ready",   duty_ready,   !m_full);
    check("duty_active",  duty_active,  m_active);
    check("seq_err",      seq_err,      m_err);
  endtask

  // Advance one clock: model the edge, check 1 ns later, then step the
  // counter. A transferred duty drops duty_valid like a real sender would.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (reset) begin
      model_reset();
      acc = 0;
    end else begin
      model_edge(int'(count), duty_valid, int'(duty_in), acc);
    end
    #1;
    compare_all();
    if (m_ps) begin
      if (per_valid && per_len == MAXC + 1) check("period_high_clks", hi_cnt, per_duty);
      hi_cnt    = int'(pwm_out);
      per_len   = 1;
      per_duty  = m_active;
      per_valid = m_run;
    end else begin
      hi_cnt  += int'(pwm_out);
      per_len += 1;
    end
    if (acc) duty_valid = 1'b0;
    count = count + 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send_duty(input int d);
    int k;
    duty_in    = W'(d);
    duty_valid = 1'b1;
    k = 0;
    while (duty_valid && k < 64) begin
      tick();
      k++;
    end
    check("handshake_timeout", duty_valid, 1'b0);
  endtask

  task automatic wait_count(input int c);
    int k;
    k = 0;
    while (int'(count) != c && k < 32) begin
      tick();
      k++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    count      = '0;
    duty_in    = '0;
    duty_valid = 1'b0;
    model_reset();

    // Reset state
    #12;
    compare_all();
    run(2);
    reset = 1'b0;

    // No duty written: pwm stays low, period_start every 16 clocks
    run(40);

    // Duty 5 written mid-period
    wait_count(9);
    send_duty(5);
    check("ready_low_after_accept", duty_ready, 1'b0);
    run(36);

    // Duty 15 then 3 back-to-back: second stalls until the boundary
    wait_count(4);
    send_duty(15);
    send_duty(3);
    check("active_after_stall", duty_active, 15);
    run(40);

    // Accept 8 exactly in the boundary cycle
    wait_count(0);
    duty_in    = W'(8);
    duty_valid = 1'b1;
    tick();
    check("bnd_accept_keeps_old", duty_active, 3);
    run(36);
    check("bnd_accept_applied", duty_active, 8);

    // Duty 0: output constantly low
    send_duty(0);
    run(36);

    // Reset at count 7 for two clocks
    send_duty(11);
    run(20);
    wait_count(7);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    reset = 1'b0;
    run(40);

`ifdef COUNT_PWM_SEQ_CHECK_EN
    // Counter jumps 6->9 while running
    send_duty(6);
    run(20);
    wait_count(6);
    tick();
    count = W'(9);
    tick();
    check("seq_err_set", seq_err, 1'b1);
    run(40);
    check("seq_duty_kept", duty_active, 6);
`endif

    // Randomised duty writes against the model
    for (int i = 0; i < 400; i++) begin
      if (!duty_valid && $urandom_range(0, 9) == 0) begin
        duty_in    = W'($urandom_range(0, MAXC));
        duty_valid = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
